// File: rtl/scan_chain_seq.sv
// scan_chain_seq: drives a mux-scan chain through load/unload and optional capture.
// Capture support is built only when SCAN_CHAIN_SEQ_CAPTURE_EN is defined.
module scan_chain_seq #(
    parameter int CHAIN_LEN = 16,
    localparam int CNT_W = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 nvdla_core_clk,
    input  logic                 nvdla_core_rstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CHAIN_LEN-1:0] cmd_data,
    input  logic                 cmd_capture,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 scan_se,
    output logic                 scan_si,
    input  logic                 scan_so,
    output logic                 scan_cken,
    output logic                 busy
);
`ifdef SCAN_CHAIN_SEQ_CAPTURE_EN
    typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
    state_t               state_q, state_d;
    logic [CHAIN_LEN-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`ifdef SCAN_CHAIN_SEQ_CAPTURE_EN
    logic                 cap_q, cap_d;
`else
    logic                 unused_cmd_capture;
    assign unused_cmd_capture = cmd_capture;
`endif
    // next-state: accept in IDLE, shift one bit per cycle, optional capture, wait for response
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SCAN_CHAIN_SEQ_CAPTURE_EN
        cap_d   = cap_q;
`endif
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = SHIFT;
                shreg_d = cmd_data;
                cnt_d   = '0;
`ifdef SCAN_CHAIN_SEQ_CAPTURE_EN
                cap_d   = cmd_capture;
`endif
            end
            SHIFT: begin
                shreg_d = {scan_so, shreg_q[CHAIN_LEN-1:1]};
                cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef SCAN_CHAIN_SEQ_CAPTURE_EN
                if (cnt_q == LAST) state_d = cap_q ? CAPTURE : DONE;
`else
                if (cnt_q == LAST) state_d = DONE;
`endif
            end
`ifdef SCAN_CHAIN_SEQ_CAPTURE_EN
            CAPTURE: state_d = DONE;
`endif
            DONE: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state registers; reset clears everything so scan controls drop at once
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef SCAN_CHAIN_SEQ_CAPTURE_EN
            cap_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef SCAN_CHAIN_SEQ_CAPTURE_EN
            cap_q   <= cap_d;
`endif
        end
    end
    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign rsp_valid = state_q == DONE;
    assign rsp_data  = shreg_q;
    assign scan_si   = shreg_q[0];
    assign scan_se   = state_q == SHIFT;
`ifdef SCAN_CHAIN_SEQ_CAPTURE_EN
    assign scan_cken = (state_q == SHIFT) || (state_q == CAPTURE);
`else
    assign scan_cken = state_q == SHIFT;
`endif
endmodule

// File: tb/tb_scan_chain_seq.sv
// tb_scan_chain_seq: bench for scan_chain_seq with an 8-flop chain model (set-reset, D tied to 0x3C).
module tb_scan_chain_seq;
    localparam int N = 8;
`ifdef SCAN_CHAIN_SEQ_CAPTURE_EN
    localparam int CAP = 1;
`else
    localparam int CAP = 0;
`endif
    localparam logic [N-1:0] CHAIN_D = 8'h3C;

    logic clk = 1'b0, rstn = 1'b0;
    logic cmd_valid = 1'b0, cmd_capture = 1'b0, rsp_ready = 1'b0;
    logic [N-1:0] cmd_data = '0;
    logic cmd_ready, rsp_valid, scan_se, scan_si, scan_so, scan_cken, busy;
    logic [N-1:0] rsp_data;
    logic [N-1:0] chain;
    int total = 0, bad = 0;
    int se_cnt = 0, cap_cnt = 0, cyc = 0;
    int acc[$];

    always #5 clk = ~clk;

    scan_chain_seq #(.CHAIN_LEN(N)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_capture(cmd_capture),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .scan_se(scan_se), .scan_si(scan_si), .scan_so(scan_so), .scan_cken(scan_cken), .busy(busy)
    );

    // the scan chain itself: bit 0 is the flop feeding scan_so
    always @(posedge clk or negedge rstn)
        if (!rstn) chain <= '1;
        else if (scan_cken) chain <= scan_se ? {scan_si, chain[N-1:1]} : CHAIN_D;
    assign scan_so = chain[0];

    always @(negedge clk) begin
        if (scan_cken && scan_se) se_cnt++;
        if (scan_cken && !scan_se) cap_cnt++;
    end

    always @(posedge clk) begin
        cyc++;
        if (cmd_valid && cmd_ready) acc.push_back(cyc);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
        chk({tag, "_scan_se"}, 32'(scan_se), 0);
        chk({tag, "_scan_si"}, 32'(scan_si), 0);
        chk({tag, "_scan_cken"}, 32'(scan_cken), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic run_cmd(input logic [N-1:0] d, input logic c, input int hold,
                           output logic [N-1:0] r, output int lat, output int se_n, output int cap_n);
        int s0, c0;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_data = d;
        cmd_capture = c;
        s0 = se_cnt;
        c0 = cap_cnt;
        chk("accept_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data = ~d;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_data), 32'(r));
            chk("hold_cmd_ready", 32'(cmd_ready), 0);
            chk("hold_cken", 32'(scan_cken), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 0);
        chk("back_idle", 32'(cmd_ready), 1);
        se_n = se_cnt - s0;
        cap_n = cap_cnt - c0;
    endtask

    typedef struct {
        logic [N-1:0] d;
        logic         c;
        int           hold;
        logic [N-1:0] exp;
        int           lat;
    } vec_t;

    initial begin
        vec_t tbl[4];
        logic [N-1:0] model, r, d;
        logic c;
        int lat, se_n, cap_n, n, s0;
        tbl[0] = '{8'hA5, 1'b0, 0, 8'hFF, N};
        tbl[1] = '{8'h00, 1'b0, 5, 8'hA5, N};
        tbl[2] = '{8'h11, 1'b1, 0, 8'h00, N + CAP};
        tbl[3] = '{8'h5A, 1'b0, 2, (CAP != 0) ? CHAIN_D : 8'h11, N};

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk_reset("reset");

        for (int i = 0; i < 4; i++) begin
            run_cmd(tbl[i].d, tbl[i].c, tbl[i].hold, r, lat, se_n, cap_n);
            chk("tbl_rsp", 32'(r), 32'(tbl[i].exp));
            chk("tbl_lat", 32'(lat), 32'(tbl[i].lat));
            chk("tbl_se_window", 32'(se_n), N);
            chk("tbl_capture_cycles", 32'(cap_n), tbl[i].c ? CAP : 0);
        end
        model = 8'h5A;

        // back-to-back commands with both handshakes held high
        @(negedge clk);
        cmd_data = 8'hC3;
        cmd_capture = 1'b0;
        rsp_ready = 1'b1;
        s0 = se_cnt;
        acc.delete();
        cmd_valid = 1'b1;
        repeat (35) @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stream_idle", 32'(busy), 0);
        rsp_ready = 1'b0;
        chk("stream_accepts", 32'(acc.size() >= 3), 1);
        for (int i = 1; i < acc.size(); i++) chk("stream_spacing", 32'(acc[i] - acc[i-1]), N + 2);
        chk("stream_se_window", 32'(se_cnt - s0), 32'(N * acc.size()));
        model = 8'hC3;

        // reset during the 4th shift cycle aborts the operation
        @(negedge clk);
        cmd_data = 8'h96;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_shifting", 32'(scan_se), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset("mid_reset");
        @(negedge clk);
        rstn = 1'b1;
        model = '1;

        for (int i = 0; i < 20; i++) begin
            d = N'($urandom);
            c = 1'($urandom_range(1, 0));
            run_cmd(d, c, $urandom_range(3, 0), r, lat, se_n, cap_n);
            chk("rand_rsp", 32'(r), 32'(model));
            chk("rand_lat", 32'(lat), (c && CAP != 0) ? N + 1 : N);
            chk("rand_se_window", 32'(se_n), N);
            chk("rand_capture_cycles", 32'(cap_n), (c && CAP != 0) ? 1 : 0);
            model = (c && CAP != 0) ? CHAIN_D : d;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
